// File: rtl/counter_reload_ctrl.sv
// rtl/counter_reload_ctrl.sv - segment sequencer driving a loadable counter's load/load_data
// Optional feature macro: COUNTER_RELOAD_CTRL_WRAP_CNT_EN (adds 8-bit saturating wrap_count output)
module counter_reload_ctrl #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH-1:0] cfg_end,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] count,
  output logic             load,
  output logic [WIDTH-1:0] load_data,
  output logic             wrap_pulse,
`ifdef COUNTER_RELOAD_CTRL_WRAP_CNT_EN
  output logic [7:0]       wrap_count,
`endif
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] q_start [DEPTH];
  logic [WIDTH-1:0] q_end   [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      q_cnt;
  logic [WIDTH-1:0] cur_start, cur_end;
  logic             stop_pending;

  logic             q_empty, q_full, push, pop, flush, set_stop, clr_stop;
  logic [WIDTH-1:0] head_start, head_end;

  assign q_empty    = (q_cnt == '0);
  assign q_full     = (q_cnt == DEPTH_C);
  assign head_start = q_start[rd_ptr];
  assign head_end   = q_end[rd_ptr];
  assign cfg_ready  = !q_full && !stop_pending;
  assign push       = cfg_valid && cfg_ready;
  assign busy       = (state == S_RUN);

  // Next state and counter control; default holds the counter by reloading its own value
  always_comb begin
    next_state = state;
    load       = 1'b1;
    load_data  = count;
    wrap_pulse = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    set_stop   = 1'b0;
    clr_stop   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!q_empty) begin
          load_data  = head_start;
          pop        = 1'b1;
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (pause) begin
          set_stop = stop;
        end else if (count == cur_end) begin
          wrap_pulse = 1'b1;
          if (stop_pending || stop) begin
            flush      = 1'b1;
            clr_stop   = 1'b1;
            next_state = S_IDLE;
          end else if (!q_empty) begin
            load_data = head_start;
            pop       = 1'b1;
          end else begin
            load_data = cur_start;
          end
        end else begin
          load     = 1'b0;
          set_stop = stop;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Queue storage; contents are don't-care until counted valid
  always_ff @(posedge clk) begin
    if (push) begin
      q_start[wr_ptr] <= cfg_start;
      q_end[wr_ptr]   <= cfg_end;
    end
  end

  // Queue pointers and occupancy; a flush keeps only a descriptor accepted in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      q_cnt  <= push ? (AW+1)'(1) : '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      q_cnt <= q_cnt + (AW+1)'(1);
      else if (!push && pop) q_cnt <= q_cnt - (AW+1)'(1);
    end
  end

  // Active segment bounds and deferred stop request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_start    <= '0;
      cur_end      <= '0;
      stop_pending <= 1'b0;
    end else begin
      if (pop) begin
        cur_start <= head_start;
        cur_end   <= head_end;
      end
      if (clr_stop)      stop_pending <= 1'b0;
      else if (set_stop) stop_pending <= 1'b1;
    end
  end

`ifdef COUNTER_RELOAD_CTRL_WRAP_CNT_EN
  // Wraps within the current segment, restarted on each new segment, saturating at 255
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           wrap_count <= 8'd0;
    else if (pop)                           wrap_count <= wrap_pulse ? 8'd1 : 8'd0;
    else if (wrap_pulse && wrap_count != 8'hFF) wrap_count <= wrap_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_counter_reload_ctrl.sv
// tb/tb_counter_reload_ctrl.sv - scoreboard bench for counter_reload_ctrl with a 4-bit loadable counter
module tb_counter_reload_ctrl;
  localparam int DEPTH = 2;
  localparam int WIDTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cfg_valid = 1'b0, stop = 1'b0, pause = 1'b0;
  logic [3:0] cfg_start = '0, cfg_end = '0;
  logic       cfg_ready, load, wrap_pulse, busy;
  logic [3:0] load_data, count;
  logic [7:0] wrap_count_w;

  always #5 clk = ~clk;

  counter_reload_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start(cfg_start), .cfg_end(cfg_end), .stop(stop), .pause(pause),
    .count(count), .load(load), .load_data(load_data), .wrap_pulse(wrap_pulse),
`ifdef COUNTER_RELOAD_CTRL_WRAP_CNT_EN
    .wrap_count(wrap_count_w),
`endif
    .busy(busy)
  );
`ifndef COUNTER_RELOAD_CTRL_WRAP_CNT_EN
  assign wrap_count_w = 8'd0;
`endif

  // The downstream 4-bit loadable counter
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)  count <= 4'd0;
    else if (load) count <= load_data;
    else           count <= count + 4'd1;
  end

  typedef struct packed { logic [3:0] s; logic [3:0] e; } seg_t;
  typedef struct { int cnt; int ld; int wr; int bz; int rdy; int wc; } exp_t;

  exp_t exp_q[$];
  seg_t m_q[$];
  bit   m_run, m_sp;
  int   m_cs, m_ce, m_c, m_wc;
  int   tests = 0, fails = 0;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_run = 0; m_sp = 0; m_cs = 0; m_ce = 0; m_c = 0; m_wc = 0;
  endtask

  // One clock: drive inputs, predict this cycle's outputs, advance the reference model
  task automatic step(input bit v, input int s, input int e, input bit st, input bit pz);
    exp_t x;
    seg_t sg;
    bit rdy, popped, wr, ld;
    int nc;
    @(posedge clk); #1;
    cfg_valid = v; cfg_start = 4'(s); cfg_end = 4'(e); stop = st; pause = pz;
    rdy = (m_q.size() < DEPTH) && !m_sp;
    x.cnt = m_c; x.bz = m_run; x.rdy = rdy; x.wc = m_wc;
    popped = 0; wr = 0; ld = 1; nc = m_c;
    if (!m_run) begin
      if (m_q.size() > 0) begin
        sg = m_q.pop_front();
        m_cs = sg.s; m_ce = sg.e; nc = m_cs; m_run = 1; popped = 1;
      end
    end else if (pz) begin
      if (st) m_sp = 1;
    end else if (m_c == m_ce) begin
      wr = 1;
      if (m_sp || st) begin
        m_q.delete(); m_sp = 0; m_run = 0;
      end else if (m_q.size() > 0) begin
        sg = m_q.pop_front();
        m_cs = sg.s; m_ce = sg.e; nc = m_cs; popped = 1;
      end else begin
        nc = m_cs;
      end
    end else begin
      ld = 0; nc = (m_c + 1) % 16;
      if (st) m_sp = 1;
    end
    if (v && rdy) m_q.push_back({4'(s), 4'(e)});
    if (popped) m_wc = wr ? 1 : 0;
    else if (wr && m_wc < 255) m_wc++;
    x.ld = ld; x.wr = wr;
    m_c = nc;
    exp_q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic run_until_count(input int val, input int max);
    int n = 0;
    while (m_c != val && n < max) begin step(0, 0, 0, 0, 0); n++; end
    if (m_c != val) begin
      fails++;
      $display("FAIL wait_count: got %0d, expected %0d within %0d cycles", m_c, val, max);
    end
  endtask

  task automatic reset_check(input string tag);
    @(posedge clk); #1;
    reset_n = 0; cfg_valid = 0; stop = 0; pause = 0;
    #1;
    chk({tag, "_load"}, load, 1);
    chk({tag, "_load_data"}, load_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cfg_ready"}, cfg_ready, 1);
    chk({tag, "_wrap"}, wrap_pulse, 0);
    chk({tag, "_wrap_count"}, wrap_count_w, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest prediction
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("count", count, mon_e.cnt);
        chk("load", load, mon_e.ld);
        chk("wrap_pulse", wrap_pulse, mon_e.wr);
        chk("busy", busy, mon_e.bz);
        chk("cfg_ready", cfg_ready, mon_e.rdy);
`ifdef COUNTER_RELOAD_CTRL_WRAP_CNT_EN
        chk("wrap_count", wrap_count_w, mon_e.wc);
`endif
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    reset_check("reset");
    idle(3);
    // basic segment
    step(1, 3, 6, 0, 0);
    idle(12);
    // queued switch to a period-1 segment
    step(1, 5, 5, 0, 0);
    idle(8);
    // wrap-around segment
    step(1, 14, 1, 0, 0);
    idle(10);
    // stop with one entry queued
    step(1, 3, 6, 0, 0);
    run_until_count(3, 20);
    step(1, 9, 10, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(8);
    // backpressure and pause on the match cycle
    step(1, 2, 6, 0, 0);
    idle(2);
    step(1, 8, 9, 0, 0);
    step(1, 10, 11, 0, 0);
    step(1, 12, 13, 0, 0);
    run_until_count(6, 20);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    idle(12);
    // reset mid-run
    reset_check("midreset");
    idle(4);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) == 0, $urandom_range(15, 0), $urandom_range(15, 0),
           ($urandom % 40) == 0, ($urandom % 8) == 0);
      if (i == 1500) reset_check("randreset");
    end
    idle(2);
    @(posedge clk); @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
